// File: rtl/xor_pipe_pkg.sv
// Shared constants, FIFO-entry layout and sizing helper for the XOR pipeline blocks.
package xor_pipe_pkg;

  localparam int unsigned XP_W         = 10;
  localparam int unsigned XP_DEPTH     = 4;
  localparam int unsigned XP_FRAME_LEN = 8;

  typedef struct packed {
    logic            last;
    logic [XP_W-1:0] data;
  } fifo_entry_t;

  // Occupancy counter width: must represent 0..depth inclusive.
  function automatic int unsigned lvl_width(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/xor_sync_fifo.sv
// First-word-fall-through synchronous FIFO; head entry is visible on dout whenever not empty.
module xor_sync_fifo
  import xor_pipe_pkg::*;
#(
  parameter int unsigned DW    = XP_W + 1,
  parameter int unsigned DEPTH = XP_DEPTH
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          push,
  input  logic                          pop,
  input  logic [DW-1:0]                 din,
  output logic [DW-1:0]                 dout,
  output logic [lvl_width(DEPTH)-1:0]   level,
  output logic                          full,
  output logic                          empty
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = lvl_width(DEPTH);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (level == LW'(DEPTH));
  assign empty = (level == '0);

  // A pop on a full FIFO frees the slot the simultaneous write lands in.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;

  assign dout = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_ptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, rd_en})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

endmodule

// File: rtl/xor_frame_packer.sv
// Buffers the XOR result stream, marks frame boundaries and produces per-frame XOR checksums.
// Optional XOR_FRAME_PACKER_DROP_COUNT_EN adds a saturating 16-bit drop counter output.
module xor_frame_packer
  import xor_pipe_pkg::*;
#(
  parameter int unsigned W         = XP_W,
  parameter int unsigned DEPTH     = XP_DEPTH,
  parameter int unsigned FRAME_LEN = XP_FRAME_LEN
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_valid,
  input  logic [W-1:0]                  in_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [W-1:0]                  out_data,
  output logic                          out_last,
  output logic [W-1:0]                  frame_csum,
  output logic                          csum_valid,
  output logic                          overflow,
  input  logic                          overflow_clr,
  output logic [lvl_width(DEPTH)-1:0]   level
`ifdef XOR_FRAME_PACKER_DROP_COUNT_EN
  ,
  output logic [15:0]                   drop_cnt
`endif
);

  localparam int unsigned CW = $clog2(FRAME_LEN);

  typedef struct packed {
    logic         last;
    logic [W-1:0] data;
  } entry_t;

  entry_t        wr_entry;
  entry_t        rd_entry;
  logic          fifo_full;
  logic          fifo_empty;
  logic          pop;
  logic          accept;
  logic          drop;
  logic          is_last;
  logic [CW-1:0] frm_cnt;
  logic [W-1:0]  acc;

  // Output handshake: a word transfers on any cycle with out_valid && out_ready;
  // out_valid never drops and head data never changes until that transfer happens.
  assign out_valid = !fifo_empty;
  assign pop       = out_valid && out_ready;
  assign accept    = in_valid && (!fifo_full || pop);
  assign drop      = in_valid && fifo_full && !pop;
  assign is_last   = (frm_cnt == CW'(FRAME_LEN - 1));

  assign wr_entry = '{last: is_last, data: in_data};
  assign out_data = rd_entry.data;
  assign out_last = rd_entry.last;

  xor_sync_fifo #(
    .DW    (W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (accept),
    .pop   (pop),
    .din   (wr_entry),
    .dout  (rd_entry),
    .level (level),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Dropped words never touch the frame counter or the checksum accumulator.
  always_ff @(posedge clk) begin
    if (rst) begin
      frm_cnt    <= '0;
      acc        <= '0;
      frame_csum <= '0;
      csum_valid <= 1'b0;
    end else begin
      csum_valid <= 1'b0;
      if (accept) begin
        if (is_last) begin
          frm_cnt    <= '0;
          acc        <= '0;
          frame_csum <= acc ^ in_data;
          csum_valid <= 1'b1;
        end else begin
          frm_cnt <= frm_cnt + 1'b1;
          acc     <= acc ^ in_data;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overflow <= 1'b0;
    end else if (drop) begin
      overflow <= 1'b1;
    end else if (overflow_clr) begin
      overflow <= 1'b0;
    end
  end

`ifdef XOR_FRAME_PACKER_DROP_COUNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (overflow_clr) begin
      drop_cnt <= drop ? 16'd1 : 16'd0;
    end else if (drop && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_xor_frame_packer.sv
// Directed bench for xor_frame_packer: vector table plus hand-written reset and drop-count sequences.
module tb_xor_frame_packer;

  localparam int W = 10;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] out_data;
  logic         out_last;
  logic [W-1:0] frame_csum;
  logic         csum_valid;
  logic         overflow;
  logic         overflow_clr;
  logic [2:0]   level;
`ifdef XOR_FRAME_PACKER_DROP_COUNT_EN
  logic [15:0]  drop_cnt;
`endif

  int n_vec = 0;
  int n_err = 0;

  xor_frame_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .frame_csum   (frame_csum),
    .csum_valid   (csum_valid),
    .overflow     (overflow),
    .overflow_clr (overflow_clr),
    .level        (level)
`ifdef XOR_FRAME_PACKER_DROP_COUNT_EN
    ,
    .drop_cnt     (drop_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic         iv;
    logic [W-1:0] id;
    logic         rdy;
    logic         clr;
    logic         ev;
    logic [W-1:0] ed;
    logic         el;
    logic [2:0]   elev;
    logic         eovf;
    logic         ecv;
    logic [W-1:0] ecs;
  } vec_t;

  vec_t tbl[$];

  // driver: apply inputs, take one edge, sample 1ns later
  task automatic drive(input logic iv, input logic [W-1:0] id, input logic rdy, input logic clr);
    in_valid     = iv;
    in_data      = id;
    out_ready    = rdy;
    overflow_clr = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic cmp(input string name, input int act, input int exp);
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic ev, input logic [W-1:0] ed, input logic el,
                           input logic [2:0] elev, input logic eovf, input logic ecv,
                           input logic [W-1:0] ecs);
    n_vec++;
    cmp({tag, ".out_valid"},  int'(out_valid),  int'(ev));
    cmp({tag, ".out_data"},   int'(out_data),   int'(ed));
    cmp({tag, ".out_last"},   int'(out_last),   int'(el));
    cmp({tag, ".level"},      int'(level),      int'(elev));
    cmp({tag, ".overflow"},   int'(overflow),   int'(eovf));
    cmp({tag, ".csum_valid"}, int'(csum_valid), int'(ecv));
    cmp({tag, ".frame_csum"}, int'(frame_csum), int'(ecs));
  endtask

  task automatic add(input logic iv, input int id, input logic rdy, input logic clr,
                     input logic ev, input int ed, input logic el, input int elev,
                     input logic eovf, input logic ecv, input int ecs);
    tbl.push_back('{iv, W'(id), rdy, clr, ev, W'(ed), el, 3'(elev), eovf, ecv, W'(ecs)});
  endtask

  initial begin
    logic [W-1:0] exp_csum;
    logic [W-1:0] d;

    // frame of 1..8 streaming straight through
    for (int k = 1; k <= 8; k++)
      add(1, k, 1, 0, 1, k, k == 8, 1, 0, k == 8, (k == 8) ? 8 : 0);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 8);
    // backpressure: fill to 4, fifth word dropped
    add(1, 'h11, 0, 0, 1, 'h11, 0, 1, 0, 0, 8);
    add(1, 'h12, 0, 0, 1, 'h11, 0, 2, 0, 0, 8);
    add(1, 'h13, 0, 0, 1, 'h11, 0, 3, 0, 0, 8);
    add(1, 'h14, 0, 0, 1, 'h11, 0, 4, 0, 0, 8);
    add(1, 'h15, 0, 0, 1, 'h11, 0, 4, 1, 0, 8);
    add(0, 0, 1, 0, 1, 'h12, 0, 3, 1, 0, 8);
    add(0, 0, 1, 0, 1, 'h13, 0, 2, 1, 0, 8);
    add(0, 0, 1, 0, 1, 'h14, 0, 1, 1, 0, 8);
    add(0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 8);
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 8);
    // four more words finish the frame begun by 0x11..0x14: csum 0x04^0x10 = 0x14
    add(1, 'h21, 0, 0, 1, 'h21, 0, 1, 0, 0, 8);
    add(1, 'h22, 0, 0, 1, 'h21, 0, 2, 0, 0, 8);
    add(1, 'h23, 0, 0, 1, 'h21, 0, 3, 0, 0, 8);
    add(1, 'h30, 0, 0, 1, 'h21, 0, 4, 0, 1, 'h14);
    // full + pop + push in one cycle: accepted, level stays 4
    add(1, 'h31, 1, 0, 1, 'h22, 0, 4, 0, 0, 'h14);
    // drop coincident with clear: set wins, then clear alone
    add(1, 'h3F, 0, 1, 1, 'h22, 0, 4, 1, 0, 'h14);
    add(0, 0, 0, 1, 1, 'h22, 0, 4, 0, 0, 'h14);
    add(0, 0, 1, 0, 1, 'h23, 0, 3, 0, 0, 'h14);
    add(0, 0, 1, 0, 1, 'h30, 1, 2, 0, 0, 'h14);
    add(0, 0, 1, 0, 1, 'h31, 0, 1, 0, 0, 'h14);
    add(0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 'h14);

    in_valid = 0; in_data = '0; out_ready = 0; overflow_clr = 0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);
    rst = 1'b0;

    for (int i = 0; i < tbl.size(); i++) begin
      drive(tbl[i].iv, tbl[i].id, tbl[i].rdy, tbl[i].clr);
      check_all($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].elev,
                tbl[i].eovf, tbl[i].ecv, tbl[i].ecs);
    end

    // partial frame plus overflow, then reset mid-frame
    for (int k = 0; k < 5; k++) drive(1, W'('h41 + k), 0, 0);
    check_all("pre_rst", 1, 'h41, 0, 4, 1, 0, 'h14);
    rst = 1'b1;
    drive(0, 0, 0, 0);
    rst = 1'b0;
    check_all("mid_rst", 0, 0, 0, 0, 0, 0, 0);

    exp_csum = '0;
    for (int k = 0; k < 8; k++) begin
      d = W'(k * 37 + 5);
      exp_csum ^= d;
      drive(1, d, 1, 0);
      check_all($sformatf("post_rst%0d", k), 1, d, k == 7, 1, 0, k == 7, (k == 7) ? exp_csum : '0);
    end
    drive(0, 0, 1, 0);
    check_all("post_rst_idle", 0, 0, 0, 0, 0, 0, exp_csum);

`ifdef XOR_FRAME_PACKER_DROP_COUNT_EN
    for (int k = 0; k < 7; k++) drive(1, W'(k + 1), 0, 0);
    n_vec++; cmp("drop_cnt_3", int'(drop_cnt), 3);
    drive(0, 0, 0, 1);
    n_vec++; cmp("drop_cnt_clr", int'(drop_cnt), 0);
    drive(1, 0, 0, 1);
    n_vec++; cmp("drop_cnt_clr_drop", int'(drop_cnt), 1);
    for (int k = 0; k < 65533; k++) drive(1, 0, 0, 0);
    n_vec++; cmp("drop_cnt_fffe", int'(drop_cnt), 'hFFFE);
    drive(1, 0, 0, 0);
    n_vec++; cmp("drop_cnt_ffff", int'(drop_cnt), 'hFFFF);
    drive(1, 0, 0, 0);
    n_vec++; cmp("drop_cnt_sat", int'(drop_cnt), 'hFFFF);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/xor_frame_packer.md
Name: xor_frame_packer

Overview:
- Sits directly downstream of the registered XOR stage. Consumes its one-cycle valid/result stream, which has no backpressure.
- Buffers results in a small FWFT FIFO and presents them on a valid/ready output with a frame-last marker every FRAME_LEN accepted words.
- Computes a per-frame XOR checksum and flags overflow when the upstream stream cannot be absorbed.

Parameters:
- W, 10, data width; matches upstream result width.
- DEPTH, 4, FIFO entries; power of 2, >= 2.
- FRAME_LEN, 8, accepted words per frame; >= 2.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  upstream result valid, one-cycle qualifier, no ready.
- in_data  in  W  upstream result.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accept.
- out_data  out  W  FIFO head data.
- out_last  out  1  head word is last of its frame.
- frame_csum  out  W  XOR of all words of the most recently completed frame.
- csum_valid  out  1  one-cycle pulse when frame_csum updates.
- overflow  out  1  sticky drop flag.
- overflow_clr  in  1  clears overflow.
- level  out  $clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (rst high at clk edge):
  - out_valid=0, out_data=0, out_last=0, frame_csum=0, csum_valid=0, overflow=0, level=0.
  - Word counter and checksum accumulator reset to 0. FIFO pointers reset to 0.
  - Reset mid-frame discards the partial frame and all buffered words.
- Pop: out_valid && out_ready. FWFT: out_valid = (level != 0); out_data/out_last are driven from the head entry with no extra latency.
- Push condition: in_valid && (level < DEPTH || pop). When the FIFO is full, a simultaneous pop frees the slot and the push is accepted.
- Latency: a word accepted at edge N appears on out_data after edge N if the FIFO was empty (out_valid high in cycle N+1).
- Drop: in_valid while full and no pop.
  - Word is discarded; word counter and accumulator are unchanged.
  - overflow <= 1.
- Overflow clear: overflow_clr clears overflow. If a drop occurs in the same cycle, set wins (overflow stays 1).
- Level: +1 on push only, -1 on pop only, unchanged on both or neither.
- Frame counter:
  - Counts accepted words 0..FRAME_LEN-1 and wraps to 0 after FRAME_LEN-1.
  - The entry stored at count FRAME_LEN-1 carries last=1; all others carry last=0.
- Checksum:
  - acc <= acc ^ in_data on each accepted non-last word.
  - On the accepted last word: frame_csum <= acc ^ in_data, csum_valid <= 1 for exactly one cycle, acc <= 0.
- Pointers wrap modulo DEPTH. Read-from-empty and write-to-full never corrupt state.
- out_data holds its value while out_valid && !out_ready (stable under backpressure).

Optional Feature:
- Macro: XOR_FRAME_PACKER_DROP_COUNT_EN.
- Defined:
  - Adds output drop_cnt, 16 bits: a saturating count of dropped words (sticks at 16'hFFFF).
  - Reset 0; cleared by overflow_clr. A drop in the same cycle as the clear yields 1.
- Undefined: no drop_cnt port and no counter logic; all other behaviour is identical.

Decomposition:
- Shared package xor_pipe_pkg:
  - Default W, DEPTH, FRAME_LEN constants.
  - A packed FIFO-entry typedef {last, data[W-1:0]}.
  - A function for the level width.
- One natural sub-module: xor_sync_fifo, a FWFT synchronous FIFO carrying W+1 bits.
  - Ports: push, pop, din, dout, level, full, empty.
  - Frame counter, checksum and overflow logic stay in the top.

Test Plan:
- Reset then 8 consecutive in_valid words 1..8 with out_ready=1:
  - out_data sequence 1..8, out_last only on 8.
  - csum_valid pulses once, frame_csum = 0x008 (XOR of 1..8).
  - level never exceeds 1.
- out_ready=0, push 5 words (DEPTH=4):
  - level=4, 5th word dropped, overflow=1.
  - Then out_ready=1 drains 1..4; the frame counter has counted only 4 words.
- Full FIFO with out_ready=1 and in_valid in the same cycle:
  - Push accepted, level stays 4, no overflow.
- overflow_clr asserted in the same cycle as a drop:
  - overflow stays 1.
  - Next cycle overflow_clr with no drop -> overflow=0.
- Assert rst after 3 words of a frame:
  - All outputs return to reset values.
  - The next 8 words form a complete frame with last on the 8th word.
- With XOR_FRAME_PACKER_DROP_COUNT_EN defined, force 3 drops:
  - drop_cnt=3.
  - overflow_clr -> 0.
  - Preload 16'hFFFE, then 2 drops -> drop_cnt=16'hFFFF (saturated).
